// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the RV64IM pipeline.
// Accepts the execute-stage result, performs loads/stores over a 64-bit
// request/ready data bus, aligns and extends load data, and registers the
// writeback result for the write-back stage.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   valid_i ... exit_i        execute-stage result and memory-op controls
//   stall_o                   upstream must hold its outputs (bus access open)
//   dbus_*                    data-bus request / response
//   valid_o ... exit_o        registered write-back outputs
//   misalign_o                one-cycle pulse for a misaligned access
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready to accept; non-mem ops retire in one cycle
// BUS   | captured load/store driven on the bus until dbus_ready_i
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [63:0] aluout_i,
    input  logic [4:0]  rf_rd_i,
    input  logic        rf_wen_i,
    input  logic        mem_en_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [63:0] store_data_i,
    input  logic [63:0] pc_i,
    input  logic        exit_i,
    output logic        stall_o,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [63:0] dbus_addr_o,
    output logic [63:0] dbus_wdata_o,
    output logic [7:0]  dbus_wstrb_o,
    input  logic        dbus_ready_i,
    input  logic [63:0] dbus_rdata_i,
    output logic        valid_o,
    output logic [4:0]  rf_rd_o,
    output logic        rf_wen_o,
    output logic [63:0] wdata_o,
    output logic [63:0] pc_o,
    output logic        exit_o,
    output logic        misalign_o
);

    typedef enum logic {IDLE, BUS} state_t;

    state_t      state, state_nxt;

    logic [63:0] cap_addr;
    logic        cap_we;
    logic [1:0]  cap_size;
    logic        cap_uns;
    logic [63:0] cap_sdata;
    logic [4:0]  cap_rd;
    logic        cap_wen;
    logic [63:0] cap_pc;
    logic        cap_exit;

    logic        in_misaligned;
    logic [63:0] rdata_shift;
    logic [63:0] load_val;
    logic [7:0]  size_mask;

    // Natural alignment: offset must be a multiple of the access size.
    always_comb begin
        in_misaligned = 1'b0;
        case (mem_size_i)
            2'd0: in_misaligned = 1'b0;
            2'd1: in_misaligned = aluout_i[0];
            2'd2: in_misaligned = |aluout_i[1:0];
            2'd3: in_misaligned = |aluout_i[2:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        dbus_req_o   = 1'b0;
        dbus_we_o    = 1'b0;
        dbus_addr_o  = 64'd0;
        dbus_wdata_o = 64'd0;
        dbus_wstrb_o = 8'd0;
        size_mask    = 8'h00;
        case (cap_size)
            2'd0: size_mask = 8'h01;
            2'd1: size_mask = 8'h03;
            2'd2: size_mask = 8'h0F;
            2'd3: size_mask = 8'hFF;
        endcase
        case (state)
            IDLE: begin
                if (valid_i && mem_en_i && !in_misaligned) begin
                    state_nxt = BUS;
                end
            end
            BUS: begin
                dbus_req_o  = 1'b1;
                dbus_we_o   = cap_we;
                dbus_addr_o = {cap_addr[63:3], 3'b000};
                if (cap_we) begin
                    dbus_wdata_o = cap_sdata << {cap_addr[2:0], 3'b000};
                    dbus_wstrb_o = size_mask << cap_addr[2:0];
                end
                if (dbus_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall_o = (state == BUS);

    // Move the addressed bytes to the bottom, then extend to 64 bits.
    assign rdata_shift = dbus_rdata_i >> {cap_addr[2:0], 3'b000};

    always_comb begin
        load_val = rdata_shift;
        case (cap_size)
            2'd0: load_val = {{56{~cap_uns & rdata_shift[7]}},  rdata_shift[7:0]};
            2'd1: load_val = {{48{~cap_uns & rdata_shift[15]}}, rdata_shift[15:0]};
            2'd2: load_val = {{32{~cap_uns & rdata_shift[31]}}, rdata_shift[31:0]};
            2'd3: load_val = rdata_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o    <= 1'b0;
            rf_rd_o    <= 5'd0;
            rf_wen_o   <= 1'b0;
            wdata_o    <= 64'd0;
            pc_o       <= 64'd0;
            exit_o     <= 1'b0;
            misalign_o <= 1'b0;
            cap_addr   <= 64'd0;
            cap_we     <= 1'b0;
            cap_size   <= 2'd0;
            cap_uns    <= 1'b0;
            cap_sdata  <= 64'd0;
            cap_rd     <= 5'd0;
            cap_wen    <= 1'b0;
            cap_pc     <= 64'd0;
            cap_exit   <= 1'b0;
        end else begin
            valid_o    <= 1'b0;
            rf_wen_o   <= 1'b0;
            misalign_o <= 1'b0;
            if (state == IDLE && valid_i) begin
                if (!mem_en_i) begin
                    valid_o  <= 1'b1;
                    wdata_o  <= aluout_i;
                    rf_rd_o  <= rf_rd_i;
                    rf_wen_o <= rf_wen_i;
                    pc_o     <= pc_i;
                    exit_o   <= exit_i;
                end else if (in_misaligned) begin
                    // Faulting address is reported on wdata_o.
                    valid_o    <= 1'b1;
                    misalign_o <= 1'b1;
                    wdata_o    <= aluout_i;
                    rf_rd_o    <= rf_rd_i;
                    pc_o       <= pc_i;
                    exit_o     <= exit_i;
                end else begin
                    cap_addr  <= aluout_i;
                    cap_we    <= mem_we_i;
                    cap_size  <= mem_size_i;
                    cap_uns   <= mem_unsigned_i;
                    cap_sdata <= store_data_i;
                    cap_rd    <= rf_rd_i;
                    cap_wen   <= rf_wen_i;
                    cap_pc    <= pc_i;
                    cap_exit  <= exit_i;
                end
            end else if (state == BUS && dbus_ready_i) begin
                valid_o  <= 1'b1;
                rf_rd_o  <= cap_rd;
                rf_wen_o <= cap_we ? 1'b0 : cap_wen;
                wdata_o  <= cap_we ? 64'd0 : load_val;
                pc_o     <= cap_pc;
                exit_o   <= cap_exit;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [63:0] aluout_i;
    logic [4:0]  rf_rd_i;
    logic        rf_wen_i;
    logic        mem_en_i;
    logic        mem_we_i;
    logic [1:0]  mem_size_i;
    logic        mem_unsigned_i;
    logic [63:0] store_data_i;
    logic [63:0] pc_i;
    logic        exit_i;
    logic        stall_o;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [63:0] dbus_addr_o;
    logic [63:0] dbus_wdata_o;
    logic [7:0]  dbus_wstrb_o;
    logic        dbus_ready_i;
    logic [63:0] dbus_rdata_i;
    logic        valid_o;
    logic [4:0]  rf_rd_o;
    logic        rf_wen_o;
    logic [63:0] wdata_o;
    logic [63:0] pc_o;
    logic        exit_o;
    logic        misalign_o;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .aluout_i       (aluout_i),
        .rf_rd_i        (rf_rd_i),
        .rf_wen_i       (rf_wen_i),
        .mem_en_i       (mem_en_i),
        .mem_we_i       (mem_we_i),
        .mem_size_i     (mem_size_i),
        .mem_unsigned_i (mem_unsigned_i),
        .store_data_i   (store_data_i),
        .pc_i           (pc_i),
        .exit_i         (exit_i),
        .stall_o        (stall_o),
        .dbus_req_o     (dbus_req_o),
        .dbus_we_o      (dbus_we_o),
        .dbus_addr_o    (dbus_addr_o),
        .dbus_wdata_o   (dbus_wdata_o),
        .dbus_wstrb_o   (dbus_wstrb_o),
        .dbus_ready_i   (dbus_ready_i),
        .dbus_rdata_i   (dbus_rdata_i),
        .valid_o        (valid_o),
        .rf_rd_o        (rf_rd_o),
        .rf_wen_o       (rf_wen_o),
        .wdata_o        (wdata_o),
        .pc_o           (pc_o),
        .exit_o         (exit_o),
        .misalign_o     (misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] wdata;
        logic        chk_wdata;
        logic [4:0]  rd;
        logic        wen;
        logic [63:0] pc;
        logic        ex;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write-back monitor: every valid_o must match the oldest expected result.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_valid", 64'd1, 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.chk_wdata) check("wb_wdata", wdata_o, mon_e.wdata);
                    check("wb_rd",  64'(rf_rd_o),    64'(mon_e.rd));
                    check("wb_wen", 64'(rf_wen_o),   64'(mon_e.wen));
                    check("wb_pc",  pc_o,            mon_e.pc);
                    check("wb_exit", 64'(exit_o),    64'(mon_e.ex));
                    check("wb_mis", 64'(misalign_o), 64'(mon_e.mis));
                end
            end else begin
                check("idle_wen", 64'(rf_wen_o),   64'd0);
                check("idle_mis", 64'(misalign_o), 64'd0);
            end
        end
    end

    task automatic alu_op(input logic [63:0] val, input logic [4:0] rd, input logic wen,
                          input logic [63:0] pc, input logic ex);
        exp_t e;
        valid_i = 1'b1; mem_en_i = 1'b0; mem_we_i = 1'b0; aluout_i = val;
        rf_rd_i = rd; rf_wen_i = wen; pc_i = pc; exit_i = ex;
        e = '{wdata: val, chk_wdata: 1'b1, rd: rd, wen: wen, pc: pc, ex: ex, mis: 1'b0};
        sb_q.push_back(e);
        @(negedge clk);
        check("alu_valid", 64'(valid_o),    64'd1);
        check("alu_noreq", 64'(dbus_req_o), 64'd0);
        check("alu_stall", 64'(stall_o),    64'd0);
        valid_i = 1'b0;
    endtask

    // Drives one aligned load/store, holds it through `waits` not-ready cycles,
    // then completes it. Leaves inputs idle at the negedge after completion.
    task automatic mem_op(input string tag, input logic [63:0] addr, input logic we,
                          input logic [1:0] size, input logic uns, input logic [63:0] sdata,
                          input logic [63:0] rdata, input int waits, input logic [4:0] rd,
                          input logic [63:0] pc, input logic [63:0] exp_w,
                          input logic [7:0] exp_strb, input logic [63:0] exp_dw);
        exp_t e;
        int   stall_cnt;
        valid_i = 1'b1; mem_en_i = 1'b1; mem_we_i = we; mem_size_i = size;
        mem_unsigned_i = uns; aluout_i = addr; store_data_i = sdata;
        rf_rd_i = rd; rf_wen_i = 1'b1; pc_i = pc; exit_i = 1'b0;
        e = '{wdata: we ? 64'd0 : exp_w, chk_wdata: 1'b1, rd: rd, wen: !we,
              pc: pc, ex: 1'b0, mis: 1'b0};
        sb_q.push_back(e);
        stall_cnt = 0;
        @(negedge clk);
        for (int i = 0; i <= waits; i++) begin
            if (stall_o) stall_cnt++;
            check({tag, "_req"},  64'(dbus_req_o), 64'd1);
            check({tag, "_addr"}, dbus_addr_o, {addr[63:3], 3'b000});
            check({tag, "_we"},   64'(dbus_we_o), 64'(we));
            check({tag, "_strb"}, 64'(dbus_wstrb_o), 64'(exp_strb));
            if (we) check({tag, "_dwdata"}, dbus_wdata_o, exp_dw);
            if (i == waits) begin
                dbus_ready_i = 1'b1;
                dbus_rdata_i = rdata;
            end else begin
                dbus_ready_i = 1'b0;
                dbus_rdata_i = {$urandom, $urandom};
            end
            @(negedge clk);
        end
        dbus_ready_i = 1'b0;
        valid_i = 1'b0; mem_en_i = 1'b0;
        check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(waits + 1));
        check({tag, "_valid"},    64'(valid_o), 64'd1);
        check({tag, "_stall_end"}, 64'(stall_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        valid_i = 1'b1; aluout_i = 64'hDEAD; rf_rd_i = 5'd3; rf_wen_i = 1'b1;
        mem_en_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'd0; mem_unsigned_i = 1'b0;
        store_data_i = 64'd0; pc_i = 64'h40; exit_i = 1'b1;
        dbus_ready_i = 1'b0; dbus_rdata_i = 64'd0;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_wdata", wdata_o, 64'd0);
        check("rst_rd",    64'(rf_rd_o), 64'd0);
        check("rst_wen",   64'(rf_wen_o), 64'd0);
        check("rst_pc",    pc_o, 64'd0);
        check("rst_exit",  64'(exit_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_req",   64'(dbus_req_o), 64'd0);
        check("rst_addr",  dbus_addr_o, 64'd0);
        check("rst_strb",  64'(dbus_wstrb_o), 64'd0);
        check("rst_mis",   64'(misalign_o), 64'd0);
        rst = 1'b0; valid_i = 1'b0;
        @(negedge clk);

        alu_op(64'h1234, 5'd5, 1'b1, 64'h100, 1'b0);

        mem_op("lb",  64'h1003, 1'b0, 2'd0, 1'b0, 64'd0, 64'h0000_0000_8000_0000, 3,
               5'd6, 64'h104, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'd0);
        mem_op("lbu", 64'h1003, 1'b0, 2'd0, 1'b1, 64'd0, 64'h0000_0000_8000_0000, 3,
               5'd6, 64'h108, 64'h0000_0000_0000_0080, 8'h00, 64'd0);
        mem_op("sh",  64'h2006, 1'b1, 2'd1, 1'b0, 64'hABCD, 64'hFFFF_FFFF_FFFF_FFFF, 1,
               5'd0, 64'h10C, 64'd0, 8'hC0, 64'hABCD_0000_0000_0000);

        // Misaligned LW: no bus access, one-cycle misalign pulse.
        valid_i = 1'b1; mem_en_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'd2;
        mem_unsigned_i = 1'b0; aluout_i = 64'h3002; rf_rd_i = 5'd9; rf_wen_i = 1'b1;
        pc_i = 64'h400; exit_i = 1'b0;
        sb_q.push_back('{wdata: 64'd0, chk_wdata: 1'b0, rd: 5'd9, wen: 1'b0,
                         pc: 64'h400, ex: 1'b0, mis: 1'b1});
        @(negedge clk);
        check("mis_req",   64'(dbus_req_o), 64'd0);
        check("mis_stall", 64'(stall_o), 64'd0);
        check("mis_pulse", 64'(misalign_o), 64'd1);
        valid_i = 1'b0; mem_en_i = 1'b0;
        @(negedge clk);
        check("mis_pulse_end", 64'(misalign_o), 64'd0);

        // Back-to-back LD (ready immediately) then ADD.
        mem_op("ld", 64'h4000, 1'b0, 2'd3, 1'b0, 64'd0, 64'h0123_4567_89AB_CDEF, 0,
               5'd10, 64'h500, 64'h0123_4567_89AB_CDEF, 8'h00, 64'd0);
        alu_op(64'h55, 5'd7, 1'b1, 64'h504, 1'b1);

        mem_op("lh",  64'h5002, 1'b0, 2'd1, 1'b0, 64'd0, 64'h0000_0000_8765_0000, 2,
               5'd11, 64'h600, 64'hFFFF_FFFF_FFFF_8765, 8'h00, 64'd0);
        mem_op("lwu", 64'h5004, 1'b0, 2'd2, 1'b1, 64'd0, 64'hF000_0000_0000_0000, 0,
               5'd12, 64'h604, 64'h0000_0000_F000_0000, 8'h00, 64'd0);
        mem_op("sb",  64'h6005, 1'b1, 2'd0, 1'b0, 64'h12, 64'd0, 0,
               5'd0, 64'h608, 64'd0, 8'h20, 64'h0000_1200_0000_0000);
        mem_op("sd",  64'h7000, 1'b1, 2'd3, 1'b0, 64'hCAFE_F00D_1234_5678, 64'd0, 2,
               5'd0, 64'h60C, 64'd0, 8'hFF, 64'hCAFE_F00D_1234_5678);

        // Invalid input produces no write-back.
        valid_i = 1'b0;
        @(negedge clk);
        check("inv_valid", 64'(valid_o), 64'd0);
        check("inv_wen",   64'(rf_wen_o), 64'd0);

        // Reset while a load waits on the bus.
        valid_i = 1'b1; mem_en_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'd3;
        aluout_i = 64'h8000; rf_rd_i = 5'd13; rf_wen_i = 1'b1; pc_i = 64'h700;
        @(negedge clk);
        check("rstbus_req_before", 64'(dbus_req_o), 64'd1);
        rst = 1'b1; valid_i = 1'b0; mem_en_i = 1'b0;
        @(negedge clk);
        check("rstbus_req",   64'(dbus_req_o), 64'd0);
        check("rstbus_valid", 64'(valid_o), 64'd0);
        check("rstbus_stall", 64'(stall_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        alu_op(64'h77, 5'd14, 1'b1, 64'h800, 1'b0);
        @(negedge clk);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV64IM pipeline, directly downstream of the execute stage. Takes the ALU result plus register-writeback and memory-op controls, performs loads and stores on a 64-bit data bus with a request/ready handshake, aligns and sign/zero-extends load data, and registers the writeback result for the write-back stage. While a bus access is outstanding it stalls upstream.

## Interface
- No parameters; data width fixed at 64, bus word 64 bits (8 byte lanes).
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_i` in 1: execute-stage outputs carry a real instruction.
- `aluout_i` in 64: ALU result; effective address for memory ops, writeback value otherwise.
- `rf_rd_i` in 5: destination register.
- `rf_wen_i` in 1: register write enable.
- `mem_en_i` in 1: instruction is a load or store.
- `mem_we_i` in 1: 1 = store, 0 = load (meaningful only with `mem_en_i`).
- `mem_size_i` in 2: 0 byte, 1 half, 2 word, 3 double.
- `mem_unsigned_i` in 1: zero-extend load (LBU/LHU/LWU).
- `store_data_i` in 64: rs2 value for stores.
- `pc_i` in 64, `exit_i` in 1: debug pass-through.
- `stall_o` out 1: upstream must hold all inputs stable.
- `dbus_req_o` out 1, `dbus_we_o` out 1, `dbus_addr_o` out 64 (8-byte aligned), `dbus_wdata_o` out 64, `dbus_wstrb_o` out 8: data-bus request.
- `dbus_ready_i` in 1: access completes this cycle; `dbus_rdata_i` in 64 valid in the same cycle for loads.
- `valid_o`, `rf_rd_o` (5), `rf_wen_o`, `wdata_o` (64), `pc_o` (64), `exit_o`: registered outputs to write-back.
- `misalign_o` out 1: one-cycle pulse, access not naturally aligned.

## Operation
- States IDLE, BUS. Input accepted when `valid_i && !stall_o`; `stall_o = (state == BUS)`.
- IDLE, accepted non-mem op: next cycle `valid_o=1`, `wdata_o=aluout_i`, `rf_rd_o/rf_wen_o/pc_o/exit_o` copied. Stay IDLE.
- IDLE, accepted mem op, aligned (`off = aluout_i[2:0]`, `off % (1<<size) == 0`): capture controls, go BUS; `valid_o=0` next cycle.
- Misaligned mem op: no bus access; next cycle `valid_o=1`, `rf_wen_o=0`, `misalign_o=1`, `pc_o=pc_i`. Stay IDLE.
- BUS: `dbus_req_o=1`, `dbus_addr_o={addr[63:3],3'b0}`, `dbus_we_o` = store. Store: `dbus_wdata_o = store_data << (8*off)`, `dbus_wstrb_o = ((1<<(1<<size))-1) << off` (SD = 0xFF). Load: `dbus_wstrb_o=0`.
- BUS with `dbus_ready_i=1`: go IDLE; next cycle `valid_o=1`. Load: `wdata_o` = `(dbus_rdata_i >> 8*off)` truncated to size, sign- or zero-extended to 64; `rf_wen_o` as captured. Store: `rf_wen_o=0`, `wdata_o=0`.
- All request outputs stable while `dbus_ready_i=0`; no timeout.
- `valid_o=0` implies `rf_wen_o=0` and `misalign_o=0`.
- Invalid input (`valid_i=0`) in IDLE: next cycle `valid_o=0`, `rf_wen_o=0`.

## Timing
- Reset: state IDLE; every output 0 (`stall_o`, `dbus_*`, `valid_o`, `rf_rd_o`, `rf_wen_o`, `wdata_o`, `pc_o`, `exit_o`, `misalign_o`).
- `rst` in BUS: `dbus_req_o` drops the cycle after the reset edge; pending access abandoned, nothing written back.
- Non-mem latency 1 cycle, full throughput.
- Mem op accepted at edge T: `dbus_req_o` high from T; ready sampled at edge T+k (k≥1); `valid_o` from T+k for one cycle; next input accepted at edge T+k+1. Minimum 2 cycles per mem op.
- `stall_o` is purely state-decoded (registered), never depends on `dbus_ready_i` combinationally.

## Test plan
- Reset then ALU op `aluout_i=0x1234`, rd=5, wen=1 -> one cycle later `valid_o=1`, `wdata_o=0x1234`, `rf_rd_o=5`, `rf_wen_o=1`; no `dbus_req_o`.
- LB addr 0x1003, rdata 0x0000_0000_8000_0000 after 3 wait cycles -> `dbus_addr_o=0x1000`, `stall_o` high 4 cycles, `wdata_o=0xFFFF_FFFF_FFFF_FF80`; LBU same -> `0x80`.
- SH addr 0x2006 data 0xABCD -> `dbus_wstrb_o=0xC0`, `dbus_wdata_o=0xABCD_0000_0000_0000`, `dbus_we_o=1`; result `rf_wen_o=0`.
- LW addr 0x3002 -> no bus request, `misalign_o=1` one cycle, `rf_wen_o=0`, `pc_o=pc_i`.
- Back-to-back LD (ready immediate) then ADD -> LD `valid_o` at T+1, ADD accepted T+2, its `valid_o` at T+3; upstream held during stall.
- `rst` asserted while BUS waiting -> `dbus_req_o=0`, `valid_o=0` after edge; subsequent ALU op completes normally.
